imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of `mips_single_cycle`. It receives a program image as a byte stream, writes it word by word into the processor's instruction memory, zero-fills unused locations, and holds the processor in reset until the image is complete. On success it releases `cpu_reset`; on a malformed image it keeps the processor in reset and flags an error.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_byte_packer.sv | 33 +++
 rtl/imem_loader.sv | 198 +++++++++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).

package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        CHK,
        FILL,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects four big-endian bytes into one 32-bit word; the first byte lands in [31:24].

module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  pos;
    logic [23:0] shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos   <= 2'd0;
            shreg <= 24'd0;
        end else if (clear) begin
            pos   <= 2'd0;
            shreg <= 24'd0;
        end else if (valid) begin
            shreg <= {shreg[15:0], byte_in};
            pos   <= pos + 2'd1;
        end
    end

    // The completed word includes the byte being accepted this cycle.
    assign word      = {shreg, byte_in};
    assign word_done = valid && (pos == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a counted program image into instruction memory, zero-fills
// the rest and holds the CPU in reset until done. Optional: IMEM_LOADER_CHECKSUM_EN.

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int HDR_BITS = HDR_BYTES * 8;
    localparam logic [HDR_BITS:0] DEPTH_HDR = (HDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    state_t state, state_nxt;

    logic [7:0]          hdr_hi;
    logic [HDR_BITS-1:0] n_full;
    logic [ADDR_W:0]     n_words;
    logic [ADDR_W:0]     word_cnt;
    logic                accept;
    logic                last_word;
    logic                fill_end;
    logic                pack_clear;
    logic                pack_valid;
    logic [31:0]         packed_word;
    logic                word_done;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    assign rx_ready = (state == HDR_HI) || (state == HDR_LO) ||
                      (state == DATA)   || (state == CHK);
    assign busy     = (state == HDR_LO) || (state == DATA) ||
                      (state == CHK)    || (state == FILL);
    assign accept     = rx_valid && rx_ready;
    assign n_full     = {hdr_hi, rx_data};
    assign last_word  = ((word_cnt + CNT_ONE) == n_words);
    assign fill_end   = (word_cnt == DEPTH_CNT);
    assign pack_valid = accept && (state == DATA);

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pack_clear),
        .valid     (pack_valid),
        .byte_in   (rx_data),
        .word      (packed_word),
        .word_done (word_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pack_clear = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = HDR_HI;
            end
            HDR_HI: begin
                if (accept) begin
                    state_nxt = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    if (n_full == '0) begin
                        state_nxt = FILL;
                    end else if ({1'b0, n_full} > DEPTH_HDR) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt  = DATA;
                        pack_clear = 1'b1;
                    end
                end
            end
            DATA: begin
                if (word_done && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = FILL;
`endif
                end
            end
            CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    state_nxt = (rx_data == csum) ? FILL : ERR;
                end
`else
                state_nxt = ERR;
`endif
            end
            FILL: begin
                if (fill_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // word_cnt is the data word index during DATA and continues as the fill address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_hi    <= 8'd0;
            n_words   <= '0;
            word_cnt  <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= 32'd0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            im_we     <= 1'b0;
            done      <= (state_nxt == DONE);
            error     <= (state_nxt == ERR);
            cpu_reset <= (state_nxt != DONE);
            case (state)
                HDR_HI: begin
                    if (accept) begin
                        hdr_hi <= rx_data;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        n_words  <= (ADDR_W + 1)'(n_full);
                        word_cnt <= '0;
                    end
                end
                DATA: begin
                    if (word_done) begin
                        im_we    <= 1'b1;
                        im_addr  <= word_cnt[ADDR_W-1:0];
                        im_wdata <= packed_word;
                        word_cnt <= word_cnt + CNT_ONE;
                    end
                end
                FILL: begin
                    if (!fill_end) begin
                        im_we    <= 1'b1;
                        im_addr  <= word_cnt[ADDR_W-1:0];
                        im_wdata <= 32'd0;
                        word_cnt <= word_cnt + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over header and data bytes; the trailer byte itself is excluded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= 8'd0;
        end else if (state == IDLE) begin
            csum <= 8'd0;
        end else if (accept && (state != CHK)) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; write traffic is logged at negedge
// and compared against hand-written images and the expected zero fill.

module tb_imem_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int LOG_SZ = 4096;

    logic              clk;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    int          vectors     = 0;
    int          miscompares = 0;
    int          wr_count    = 0;
    int          base;
    int          log_addr [0:LOG_SZ-1];
    logic [31:0] log_data [0:LOG_SZ-1];
    logic [31:0] img [$];
    logic [7:0]  tb_cs;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (wr_count < LOG_SZ) begin
                log_addr[wr_count] = int'(im_addr);
                log_data[wr_count] = im_wdata;
            end
            wr_count = wr_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int budget;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        budget   = 0;
        while (rx_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) checkOutput("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
    endtask

    function automatic int pick_gap(input int gmax);
        return (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    endfunction

    task automatic idle_bus();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_header(input logic [15:0] n, input int gmax);
        tb_cs = n[15:8] ^ n[7:0];
        applyStimulus(n[15:8], pick_gap(gmax));
        applyStimulus(n[7:0], pick_gap(gmax));
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax);
        logic [7:0] b;
        for (int j = 3; j >= 0; j--) begin
            b     = w[j*8 +: 8];
            tb_cs = tb_cs ^ b;
            applyStimulus(b, pick_gap(gmax));
        end
    endtask

    task automatic send_trailer(input bit bad);
`ifdef IMEM_LOADER_CHECKSUM_EN
        applyStimulus(bad ? (tb_cs ^ 8'h04) : tb_cs, 0);
`else
        if (bad) $display("[TB] no checksum trailer in this build");
`endif
    endtask

    task automatic send_image(input logic [15:0] n, input int gmax, input bit bad);
        send_header(n, gmax);
        for (int i = 0; i < img.size(); i++) send_word(img[i], gmax);
        send_trailer(bad);
        idle_bus();
    endtask

    task automatic wait_finish();
        int budget;
        budget = 0;
        while (!(done === 1'b1 || error === 1'b1) && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("finish_timeout", 32'(done | error), 32'd1);
    endtask

    task automatic verify_run(input int from);
        logic [31:0] exp_w;
        checkOutput("write_count", 32'(wr_count - from), 32'(DEPTH));
        for (int k = 0; k < DEPTH; k++) begin
            if (from + k < LOG_SZ) begin
                exp_w = (k < img.size()) ? img[k] : 32'd0;
                checkOutput("write_addr", 32'(log_addr[from + k]), 32'(k));
                checkOutput("write_data", log_data[from + k], exp_w);
            end
        end
        checkOutput("done_set", 32'(done), 32'd1);
        checkOutput("cpu_released", 32'(cpu_reset), 32'd0);
        checkOutput("no_error", 32'(error), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        @(negedge clk);
        checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("rst_im_we", 32'(im_we), 32'd0);
        checkOutput("rst_im_addr", 32'(im_addr), 32'd0);
        checkOutput("rst_im_wdata", im_wdata, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        end
        reset = 1'b0;
        checkOutput("idle_rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        checkOutput("hdr_rx_ready", 32'(rx_ready), 32'd1);
        checkOutput("hdr_busy", 32'(busy), 32'd0);
        base = wr_count;
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;

        // Ten-word program sent back to back, with write timing checked on word 0
        do_reset();
        img = '{32'h20090005, 32'h200A000A, 32'h012A4020, 32'hAC080000, 32'h8C0B0000,
                32'h016A6022, 32'h11800002, 32'h21080001, 32'h01095025, 32'h08000000};
        send_header(16'h000A, 0);
        #1;
        checkOutput("busy_after_hdr", 32'(busy), 32'd1);
        send_word(img[0], 0);
        #1;
        checkOutput("first_we", 32'(im_we), 32'd1);
        checkOutput("first_addr", 32'(im_addr), 32'd0);
        checkOutput("first_data", im_wdata, 32'h20090005);
        for (int i = 1; i < img.size(); i++) send_word(img[i], 0);
        send_trailer(1'b0);
        idle_bus();
        wait_finish();
        verify_run(base);

        // Empty image: everything is zero fill
        do_reset();
        img = {};
        send_image(16'h0000, 0, 1'b0);
        wait_finish();
        verify_run(base);

        // Oversized count is rejected without any writes
        do_reset();
        send_header(16'h0101, 0);
        #1;
        checkOutput("err_flag", 32'(error), 32'd1);
        checkOutput("err_cpu_reset", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        checkOutput("err_rx_ready", 32'(rx_ready), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("err_writes", 32'(wr_count - base), 32'd0);
        checkOutput("err_sticky", 32'(error), 32'd1);
        checkOutput("err_no_done", 32'(done), 32'd0);
        idle_bus();

        // Random valid gaps must not drop or duplicate bytes
        do_reset();
        img = '{32'hDEADBEEF, 32'h01234567, 32'hA5C3F00F};
        send_image(16'h0003, 3, 1'b0);
        wait_finish();
        verify_run(base);

        // Reset in the middle of a 5-word image, then a fresh 1-word image
        do_reset();
        img = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        send_header(16'h0005, 0);
        send_word(img[0], 0);
        send_word(img[1], 0);
        idle_bus();
        repeat (3) @(negedge clk);
        checkOutput("partial_writes", 32'(wr_count - base), 32'd2);
        checkOutput("partial_cpu_reset", 32'(cpu_reset), 32'd1);
        do_reset();
        img = '{32'h24080007};
        send_image(16'h0001, 0, 1'b0);
        wait_finish();
        verify_run(base);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        img = '{32'hCAFEF00D, 32'h00FF00FF};
        send_image(16'h0002, 0, 1'b0);
        wait_finish();
        verify_run(base);

        do_reset();
        send_image(16'h0002, 0, 1'b1);
        wait_finish();
        checkOutput("csum_error", 32'(error), 32'd1);
        checkOutput("csum_cpu_reset", 32'(cpu_reset), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("csum_no_fill", 32'(wr_count - base), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
